wm_mode_ctrl: RTL and testbench

- Top-level operating-mode sequencer for the washing machine.
- Converts raw power, start/pause and mode pushbuttons, the door switch and the timer's status into the 3-bit `state` and `set_data` codes that drive the time controller.
- Generates the shared seconds tick and the buzzer output.
- Sits between the board I/O and the time controller / display path.

---
 rtl/wm_mode_ctrl.sv | 134 +++++++++++++
 tb/tb_wm_mode_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wm_mode_ctrl.sv
// wm_mode_ctrl: washing-machine operating-mode sequencer with tick divider and buzzer
module wm_mode_ctrl #(
  parameter int TICK_DIV   = 1000,
  parameter int BUZZ_TICKS = 5
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       power_btn,
  input  logic       start_btn,
  input  logic       mode_btn,
  input  logic       door_open,
  input  logic [3:0] init_time,
  input  logic       had_finish,
  output logic [2:0] state,
  output logic [2:0] set_data,
  output logic       tick,
  output logic       buzzer,
  output logic       power_led
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BUZZ_TICKS + 1);
  typedef enum logic [2:0] {
    S_SHUT  = 3'd0,
    S_BEGIN = 3'd1,
    S_SET   = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4,
    S_PAUSE = 3'd5,
    S_FIN   = 3'd6
  } state_e;
  logic [2:0]    s1_q, s2_q, prev_q;
  logic [1:0]    door_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    set_q, set_d;
  logic          buzz_q, buzz_d;
  state_e        state_q, state_d;
  logic          pwr_p, start_p, mode_p, door;
  // Button bits are {mode, start, power}; edge detect compares the synced value to its previous copy
  assign pwr_p   = s2_q[0] & ~prev_q[0];
  assign start_p = s2_q[1] & ~prev_q[1];
  assign mode_p  = s2_q[2] & ~prev_q[2];
  assign door    = door_q[1];
  assign tick    = cnt_q == CW'(TICK_DIV - 1);
  // Synchronizers, edge-detect history and free-running tick divider
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      door_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= {mode_btn, start_btn, power_btn};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      door_q <= {door_q[0], door_open};
      cnt_q  <= tick ? '0 : cnt_q + CW'(1);
    end
  end
  // Mode state, programme select, buzzer and buzz counter registers
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state_q <= S_SHUT;
      set_q   <= '0;
      buzz_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      buzz_q  <= buzz_d;
      bcnt_q  <= bcnt_d;
    end
  end
  // Next-state logic: power press overrides everything, then door, start, had_finish, timers
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    buzz_d  = 1'b0;
    bcnt_d  = '0;
    if (state_q != S_SHUT && pwr_p) begin
      state_d = S_SHUT;
      set_d   = '0;
    end else begin
      case (state_q)
        S_SHUT:  state_d = pwr_p ? S_BEGIN : S_SHUT;
        S_BEGIN: begin
          if (init_time == 4'd0) begin
            state_d = S_SET;
            set_d   = '0;
          end
        end
        S_SET: begin
          if (mode_p) set_d = (set_q == 3'd6) ? 3'd0 : set_q + 3'd1;
          if (start_p && !door) state_d = S_RUN;
        end
        S_RUN: begin
          if (door) state_d = S_ERR;
          else if (start_p) state_d = S_PAUSE;
          else if (had_finish) begin
            state_d = S_FIN;
            buzz_d  = 1'b1;
          end
        end
        S_PAUSE: state_d = (start_p && !door) ? S_RUN : S_PAUSE;
        S_ERR: begin
          buzz_d = buzz_q ^ tick;
          if (start_p && !door) begin
            state_d = S_RUN;
            buzz_d  = 1'b0;
          end
        end
        S_FIN: begin
          buzz_d = 1'b1;
          bcnt_d = tick ? bcnt_q + BW'(1) : bcnt_q;
          if (tick && bcnt_q == BW'(BUZZ_TICKS - 1)) begin
            state_d = S_SHUT;
            set_d   = '0;
            buzz_d  = 1'b0;
            bcnt_d  = '0;
          end
        end
        default: begin
          state_d = S_SHUT;
          set_d   = '0;
        end
      endcase
    end
  end
  assign state     = state_q;
  assign set_data  = set_q;
  assign buzzer    = buzz_q;
  assign power_led = state_q != S_SHUT;
endmodule

// File: tb/tb_wm_mode_ctrl.sv
// tb_wm_mode_ctrl: scoreboard bench for the washing-machine mode sequencer
module tb_wm_mode_ctrl;
  localparam int TD = 4;
  localparam int BT = 3;
  logic       cp = 1'b0;
  logic       rst, power_btn, start_btn, mode_btn, door_open, had_finish;
  logic [3:0] init_time;
  logic [2:0] state, set_data;
  logic       tick, buzzer, power_led;
  typedef struct {
    int         due;
    string      nm;
    logic [8:0] val;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   rel = 0;
  bit   rel_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wm_mode_ctrl #(.TICK_DIV(TD), .BUZZ_TICKS(BT)) dut (
    .cp(cp), .rst(rst), .power_btn(power_btn), .start_btn(start_btn),
    .mode_btn(mode_btn), .door_open(door_open), .init_time(init_time),
    .had_finish(had_finish), .state(state), .set_data(set_data),
    .tick(tick), .buzzer(buzzer), .power_led(power_led)
  );
  always #5 cp = ~cp;
  function automatic logic tk(input int d);
    return rel_ok && (((d - rel) % TD) == TD - 1);
  endfunction
  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got led=%b tick=%b bz=%b sd=%0d st=%0d expected led=%b tick=%b bz=%b sd=%0d st=%0d",
               nm, cyc, act[8], act[7], act[6], act[5:3], act[2:0], exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
    end
  endtask
  task automatic exp_abs(input int d, input string nm, input logic [2:0] st, input logic [2:0] sd, input logic bz);
    exp_t e;
    e.due = d;
    e.nm  = nm;
    e.val = {st != 3'd0, tk(d), bz, sd, st};
    sb.push_back(e);
  endtask
  task automatic exp_at(input int k, input string nm, input logic [2:0] st, input logic [2:0] sd, input logic bz);
    exp_abs(cyc + k, nm, st, sd, bz);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge cp);
  endtask
  task automatic press(input int b, input int hold);
    if (b == 0) power_btn = 1'b1; else if (b == 1) start_btn = 1'b1; else mode_btn = 1'b1;
    step(hold);
    power_btn = 1'b0;
    start_btn = 1'b0;
    mode_btn  = 1'b0;
    step(3);
  endtask
  // Monitor: pops every expectation due at this edge and compares shortly after it
  always @(posedge cp) begin
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation due=%0d now=%0d", e.nm, e.due, cyc);
      end else chk(e.nm, {power_led, tick, buzzer, set_data, state}, e.val);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int   e0, f0, d, n, off;
    logic bz;
    rst = 1'b1; power_btn = 1'b0; start_btn = 1'b0; mode_btn = 1'b0;
    door_open = 1'b0; had_finish = 1'b0; init_time = 4'd5;
    step(2);
    exp_at(1, "reset", 3'd0, 3'd0, 1'b0);
    step(1);
    rst = 1'b0; rel = cyc; rel_ok = 1'b1;
    step(1);
    exp_at(2, "pwr_latency", 3'd0, 3'd0, 1'b0);
    exp_at(3, "pwr_on", 3'd1, 3'd0, 1'b0);
    press(0, 1);
    exp_at(1, "begin_hold", 3'd1, 3'd0, 1'b0);
    step(1);
    init_time = 4'd0;
    exp_at(1, "to_set", 3'd2, 3'd0, 1'b0);
    step(1);
    for (int i = 1; i <= 8; i++) begin
      exp_at(3, "mode_step", 3'd2, 3'(i % 7), 1'b0);
      press(2, 1);
    end
    exp_at(3, "mode_hold", 3'd2, 3'd2, 1'b0);
    exp_at(22, "mode_hold_once", 3'd2, 3'd2, 1'b0);
    press(2, 20);
    door_open = 1'b1;
    step(3);
    exp_at(3, "set_door_start", 3'd2, 3'd2, 1'b0);
    press(1, 1);
    door_open = 1'b0;
    step(3);
    exp_at(3, "run", 3'd3, 3'd2, 1'b0);
    press(1, 1);
    exp_at(3, "pause", 3'd5, 3'd2, 1'b0);
    press(1, 1);
    exp_at(3, "resume", 3'd3, 3'd2, 1'b0);
    press(1, 1);
    door_open = 1'b1;
    exp_at(2, "door_latency", 3'd3, 3'd2, 1'b0);
    exp_at(3, "error", 3'd4, 3'd2, 1'b0);
    e0 = cyc + 3;
    bz = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      bz = bz ^ tk(e0 + j - 1);
      exp_abs(e0 + j, "err_buzz", 3'd4, 3'd2, bz);
    end
    step(13);
    door_open = 1'b0;
    step(3);
    exp_at(3, "err_resume", 3'd3, 3'd2, 1'b0);
    press(1, 1);
    had_finish = 1'b1;
    f0 = cyc + 1;
    exp_abs(f0, "finish", 3'd6, 3'd2, 1'b1);
    n = 0;
    d = f0;
    while (n < BT) begin
      if (tk(d)) n++;
      d++;
    end
    off = d;
    for (int j = f0 + 1; j < off; j++) exp_abs(j, "finish_buzz", 3'd6, 3'd2, 1'b1);
    exp_abs(off, "auto_off", 3'd0, 3'd0, 1'b0);
    step(1);
    had_finish = 1'b0;
    step(off - cyc + 1);
    exp_at(3, "pwr2", 3'd1, 3'd0, 1'b0);
    exp_at(4, "set2_min_begin", 3'd2, 3'd0, 1'b0);
    press(0, 1);
    exp_at(3, "run2", 3'd3, 3'd0, 1'b0);
    press(1, 1);
    door_open = 1'b1;
    exp_at(3, "pwr_beats_door", 3'd0, 3'd0, 1'b0);
    exp_at(4, "shut_ignores_door", 3'd0, 3'd0, 1'b0);
    press(0, 1);
    door_open = 1'b0;
    step(3);
    exp_at(3, "pwr3", 3'd1, 3'd0, 1'b0);
    exp_at(4, "set3", 3'd2, 3'd0, 1'b0);
    press(0, 1);
    exp_at(3, "run3", 3'd3, 3'd0, 1'b0);
    press(1, 1);
    exp_at(3, "pause3", 3'd5, 3'd0, 1'b0);
    press(1, 1);
    step(2);
    #2 rst = 1'b1;
    rel_ok = 1'b0;
    #1 chk("async_reset", {power_led, tick, buzzer, set_data, state}, 9'd0);
    step(1);
    rst = 1'b0; rel = cyc; rel_ok = 1'b1;
    for (int k = 1; k <= 5; k++) exp_at(k, "tick_restart", 3'd0, 3'd0, 1'b0);
    step(7);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
